// File: rtl/store_align_unit.sv
// store_align_unit: memory-stage store formatter.
// Takes one store per valid/ready handshake. Each store becomes one or two word-aligned
// bus write beats carrying lane-shifted data and byte strobes. A store whose bytes
// spill past the end of a bus word is either split across two beats or, when
// splitting is disabled, rejected with a one-cycle MisalignFault pulse.
module store_align_unit #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    StoreValidM,
  output logic                    StoreReadyM,
  input  logic [1:0]              StoreSrcM,
  input  logic [ADDR_WIDTH-1:0]   StoreAddrM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  output logic                    MemValid,
  input  logic                    MemReady,
  output logic [ADDR_WIDTH-1:0]   MemAddr,
  output logic [DATA_WIDTH-1:0]   MemWData,
  output logic [DATA_WIDTH/8-1:0] MemWStrb,
  output logic                    MisalignFault
);

  localparam int B   = DATA_WIDTH / 8;
  localparam int OFS = $clog2(B);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(B);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } state_t;

  state_t                  state_r;
  logic                    mem_valid_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;
  logic [B-1:0]            mem_wstrb_r;
  logic                    fault_r;
  logic                    split_r;
  logic [ADDR_WIDTH-1:0]   hi_addr_r;
  logic [DATA_WIDTH-1:0]   hi_wdata_r;
  logic [B-1:0]            hi_wstrb_r;

  logic [OFS-1:0]          offset_s;
  logic [ADDR_WIDTH-1:0]   base_s;
  logic [2*B-1:0]          lane_mask_s;
  logic [DATA_WIDTH-1:0]   data_mask_s;
  logic [2*DATA_WIDTH-1:0] data2_s;
  logic [2*B-1:0]          strb2_s;
  logic                    misaligned_s;
  logic                    size_ok_s;
  logic                    legal_s;
  logic                    crossing_s;
  logic                    last_beat_s;
  logic                    ready_s;
  logic                    accept_s;

  // Decode access size into a right-justified lane mask and a natural-alignment check.
  always_comb begin
    lane_mask_s  = '0;
    misaligned_s = 1'b0;
    case (StoreSrcM)
      2'b01: begin
        lane_mask_s[0]   = 1'b1;
        misaligned_s     = 1'b0;
      end
      2'b10: begin
        lane_mask_s[1:0] = 2'b11;
        misaligned_s     = StoreAddrM[0];
      end
      2'b00: begin
        lane_mask_s[3:0] = 4'hF;
        misaligned_s     = |StoreAddrM[1:0];
      end
      2'b11: begin
        lane_mask_s[7:0] = 8'hFF;
        misaligned_s     = |StoreAddrM[2:0];
      end
      default: begin
        lane_mask_s  = '0;
        misaligned_s = 1'b1;
      end
    endcase
  end

  // Position data and strobes across a double-width window so the spill into the next word is visible.
  always_comb begin
    data_mask_s = '0;
    for (int i = 0; i < B; i++) begin
      data_mask_s[8*i +: 8] = {8{lane_mask_s[i]}};
    end
    offset_s   = StoreAddrM[OFS-1:0];
    base_s     = {StoreAddrM[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
    data2_s    = {{DATA_WIDTH{1'b0}}, WriteDataM & data_mask_s} << {offset_s, 3'b000};
    strb2_s    = lane_mask_s << offset_s;
    crossing_s = |strb2_s[2*B-1:B];
    // Doubleword stores only exist on a 64-bit bus.
    size_ok_s  = (StoreSrcM != 2'b11) || (DATA_WIDTH == 32'd64);
    legal_s    = size_ok_s && (SPLIT_MISALIGNED || !misaligned_s);
  end

  // A new store may enter when idle or while the final beat of the current store completes.
  always_comb begin
    last_beat_s = (state_r == BEAT1) || ((state_r == BEAT0) && !split_r);
    if (reset) begin
      ready_s = 1'b0;
    end else begin
      ready_s = (state_r == IDLE) || (last_beat_s && mem_valid_r && MemReady);
    end
    accept_s = StoreValidM && ready_s;
  end

  // Beat sequencer: loads beat 0 on accept, advances to beat 1 for split stores, pulses faults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      mem_valid_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_wstrb_r <= '0;
      fault_r     <= 1'b0;
      split_r     <= 1'b0;
      hi_addr_r   <= '0;
      hi_wdata_r  <= '0;
      hi_wstrb_r  <= '0;
    end else begin
      fault_r <= 1'b0;
      if (accept_s) begin
        if (legal_s) begin
          state_r     <= BEAT0;
          mem_valid_r <= 1'b1;
          mem_addr_r  <= base_s;
          mem_wdata_r <= data2_s[DATA_WIDTH-1:0];
          mem_wstrb_r <= strb2_s[B-1:0];
          split_r     <= crossing_s;
          hi_addr_r   <= base_s + BEAT_BYTES;
          hi_wdata_r  <= data2_s[2*DATA_WIDTH-1:DATA_WIDTH];
          hi_wstrb_r  <= strb2_s[2*B-1:B];
        end else begin
          // Illegal store is consumed without producing any bus beat.
          state_r     <= IDLE;
          mem_valid_r <= 1'b0;
          mem_addr_r  <= '0;
          mem_wdata_r <= '0;
          mem_wstrb_r <= '0;
          split_r     <= 1'b0;
          fault_r     <= 1'b1;
        end
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          BEAT0: begin
            if (MemReady && split_r) begin
              state_r     <= BEAT1;
              mem_addr_r  <= hi_addr_r;
              mem_wdata_r <= hi_wdata_r;
              mem_wstrb_r <= hi_wstrb_r;
            end else if (MemReady) begin
              state_r     <= IDLE;
              mem_valid_r <= 1'b0;
              mem_addr_r  <= '0;
              mem_wdata_r <= '0;
              mem_wstrb_r <= '0;
            end else begin
              state_r <= BEAT0;
            end
          end
          BEAT1: begin
            if (MemReady) begin
              state_r     <= IDLE;
              mem_valid_r <= 1'b0;
              mem_addr_r  <= '0;
              mem_wdata_r <= '0;
              mem_wstrb_r <= '0;
              split_r     <= 1'b0;
            end else begin
              state_r <= BEAT1;
            end
          end
          default: begin
            state_r     <= IDLE;
            mem_valid_r <= 1'b0;
            split_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign StoreReadyM   = ready_s;
  assign MemValid      = mem_valid_r;
  assign MemAddr       = mem_addr_r;
  assign MemWData      = mem_wdata_r;
  assign MemWStrb      = mem_wstrb_r;
  assign MisalignFault = fault_r;

endmodule

// File: tb/tb_store_align_unit.sv
// tb_store_align_unit: drives three store_align_unit instances (32-bit split, 32-bit
// no-split, 64-bit split) with one shared stimulus stream and compares every cycle
// against a queue-of-beats reference model computed from byte arithmetic.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        store_valid;
  logic [1:0]  store_src;
  logic [31:0] store_addr;
  logic [63:0] wdata;
  logic        mem_ready;

  logic [2:0]       rdy_v;
  logic [2:0]       mval_v;
  logic [2:0]       mflt_v;
  logic [2:0][31:0] maddr_v;
  logic [31:0]      wd0, wd1;
  logic [63:0]      wd2;
  logic [3:0]       sb0, sb1;
  logic [7:0]       sb2;
  logic [63:0]      wd_a [3];
  logic [7:0]       sb_a [3];

  assign wd_a[0] = {32'h0, wd0};
  assign wd_a[1] = {32'h0, wd1};
  assign wd_a[2] = wd2;
  assign sb_a[0] = {4'h0, sb0};
  assign sb_a[1] = {4'h0, sb1};
  assign sb_a[2] = sb2;

  always #5 clk = ~clk;

  store_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b1)) dut_split32 (
    .clk(clk), .reset(reset), .StoreValidM(store_valid), .StoreReadyM(rdy_v[0]),
    .StoreSrcM(store_src), .StoreAddrM(store_addr), .WriteDataM(wdata[31:0]),
    .MemValid(mval_v[0]), .MemReady(mem_ready), .MemAddr(maddr_v[0]), .MemWData(wd0),
    .MemWStrb(sb0), .MisalignFault(mflt_v[0]));

  store_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b0)) dut_nosplit32 (
    .clk(clk), .reset(reset), .StoreValidM(store_valid), .StoreReadyM(rdy_v[1]),
    .StoreSrcM(store_src), .StoreAddrM(store_addr), .WriteDataM(wdata[31:0]),
    .MemValid(mval_v[1]), .MemReady(mem_ready), .MemAddr(maddr_v[1]), .MemWData(wd1),
    .MemWStrb(sb1), .MisalignFault(mflt_v[1]));

  store_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b1)) dut_split64 (
    .clk(clk), .reset(reset), .StoreValidM(store_valid), .StoreReadyM(rdy_v[2]),
    .StoreSrcM(store_src), .StoreAddrM(store_addr), .WriteDataM(wdata),
    .MemValid(mval_v[2]), .MemReady(mem_ready), .MemAddr(maddr_v[2]), .MemWData(wd2),
    .MemWStrb(sb2), .MisalignFault(mflt_v[2]));

  int cmp_count = 0;
  int err_count = 0;

  // Reference model: per instance, the list of beats still owed to the bus (head is on the bus).
  int          dwid [3] = '{32, 32, 64};
  bit          spl  [3] = '{1'b1, 1'b0, 1'b1};
  int          pc   [3];
  logic [31:0] pa   [3][2];
  logic [63:0] pd   [3][2];
  logic [7:0]  ps   [3][2];
  bit          mf   [3];
  bit          synced   = 1'b0;
  bit          rst_prev = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] src);
    case (src)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b00:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic void push_beat(input int k, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    pa[k][pc[k]] = a;
    pd[k][pc[k]] = d;
    ps[k][pc[k]] = s;
    pc[k]++;
  endfunction

  // One clock cycle: apply inputs, check ready, advance the model, then check registered outputs.
  task automatic step(input bit rst, input bit sv, input logic [1:0] src, input logic [31:0] a,
                      input logic [63:0] d, input bit mr);
    int n, bb, o;
    bit rdy, acc, legal;
    logic [31:0]  base;
    logic [127:0] d2;
    logic [15:0]  s2;
    reset = rst; store_valid = sv; store_src = src; store_addr = a; wdata = d; mem_ready = mr;
    #1;
    for (int k = 0; k < 3; k++) begin
      rdy = !rst && (pc[k] == 0 || (pc[k] == 1 && mr));
      if (rst || synced) check_val($sformatf("ready%0d", k), 64'(rdy_v[k]), 64'(rdy));
      acc = sv && rdy;
      if (rst) begin
        pc[k] = 0;
        mf[k] = 1'b0;
      end else begin
        mf[k] = 1'b0;
        if (mr && pc[k] > 0) begin
          pa[k][0] = pa[k][1]; pd[k][0] = pd[k][1]; ps[k][0] = ps[k][1];
          pc[k]--;
        end
        if (acc) begin
          n     = nbytes(src);
          bb    = dwid[k] / 8;
          o     = int'(a % 32'(bb));
          base  = a - 32'(o);
          legal = !(src == 2'b11 && dwid[k] == 32) && (spl[k] || (a % 32'(n)) == 32'h0);
          if (!legal) begin
            mf[k] = 1'b1;
          end else begin
            d2 = ({64'h0, d} & ((128'h1 << (8 * n)) - 128'h1)) << (8 * o);
            s2 = ((16'h1 << n) - 16'h1) << o;
            push_beat(k, base, 64'(d2 & ((128'h1 << dwid[k]) - 128'h1)), 8'(s2 & ((16'h1 << bb) - 16'h1)));
            if ((s2 >> bb) != 16'h0) push_beat(k, base + 32'(bb), 64'(d2 >> dwid[k]), 8'(s2 >> bb));
          end
        end
      end
    end
    if (rst) synced = 1'b1;
    rst_prev = rst;
    @(posedge clk);
    @(negedge clk);
    if (synced) begin
      for (int k = 0; k < 3; k++) begin
        check_val($sformatf("valid%0d", k), 64'(mval_v[k]), 64'(pc[k] > 0));
        check_val($sformatf("fault%0d", k), 64'(mflt_v[k]), 64'(mf[k]));
        if (pc[k] > 0) begin
          check_val($sformatf("addr%0d", k), 64'(maddr_v[k]), 64'(pa[k][0]));
          check_val($sformatf("wdata%0d", k), wd_a[k], pd[k][0]);
          check_val($sformatf("strb%0d", k), 64'(sb_a[k]), 64'(ps[k][0]));
        end else if (rst_prev) begin
          check_val($sformatf("rst_addr%0d", k), 64'(maddr_v[k]), 64'h0);
          check_val($sformatf("rst_wdata%0d", k), wd_a[k], 64'h0);
          check_val($sformatf("rst_strb%0d", k), 64'(sb_a[k]), 64'h0);
        end
      end
    end
  endtask

  task automatic idle(input bit mr);
    step(1'b0, 1'b0, 2'b00, 32'h0, 64'h0, mr);
  endtask

  initial begin
    logic [31:0] ra;
    logic [63:0] rd;
    int          sel;
    reset = 1'b1; store_valid = 1'b0; store_src = 2'b00; store_addr = 32'h0; wdata = 64'h0; mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin pc[k] = 0; mf[k] = 1'b0; end
    @(negedge clk);
    step(1'b1, 1'b0, 2'b00, 32'h0, 64'h0, 1'b0);
    step(1'b1, 1'b1, 2'b00, 32'h0, 64'h0, 1'b1);
    idle(1'b1);

    // Full word store.
    step(1'b0, 1'b1, 2'b00, 32'h100, 64'hDEADBEEF, 1'b1);
    check_val("t1_valid", 64'(mval_v[0]), 64'h1);
    check_val("t1_addr", 64'(maddr_v[0]), 64'h100);
    check_val("t1_wdata", 64'(wd0), 64'hDEADBEEF);
    check_val("t1_strb", 64'(sb0), 64'hF);

    // Byte then half back to back.
    step(1'b0, 1'b1, 2'b01, 32'h103, 64'h123456AB, 1'b1);
    check_val("t2_wdata", 64'(wd0), 64'hAB000000);
    check_val("t2_strb", 64'(sb0), 64'h8);
    step(1'b0, 1'b1, 2'b10, 32'h102, 64'hCAFE, 1'b1);
    check_val("t2b_valid", 64'(mval_v[0]), 64'h1);
    check_val("t2b_wdata", 64'(wd0), 64'hCAFE0000);
    check_val("t2b_strb", 64'(sb0), 64'hC);
    idle(1'b1);

    // Crossing half: split on one instance, fault on the other.
    step(1'b0, 1'b1, 2'b10, 32'h103, 64'h0000CAFE, 1'b1);
    check_val("t3_addr0", 64'(maddr_v[0]), 64'h100);
    check_val("t3_wdata0", 64'(wd0), 64'hFE000000);
    check_val("t3_strb0", 64'(sb0), 64'h8);
    check_val("t4_fault", 64'(mflt_v[1]), 64'h1);
    check_val("t4_novalid", 64'(mval_v[1]), 64'h0);
    step(1'b0, 1'b1, 2'b00, 32'h300, 64'h5555, 1'b1);
    check_val("t3_addr1", 64'(maddr_v[0]), 64'h104);
    check_val("t3_wdata1", 64'(wd0), 64'h000000CA);
    check_val("t3_strb1", 64'(sb0), 64'h1);
    check_val("t4_pulse_end", 64'(mflt_v[1]), 64'h0);
    idle(1'b1);
    idle(1'b1);

    // Backpressure hold.
    step(1'b0, 1'b1, 2'b00, 32'h200, 64'h89ABCDEF, 1'b1);
    idle(1'b0); idle(1'b0); idle(1'b0);
    idle(1'b1);

    // Reset during beat 0 of a split store.
    step(1'b0, 1'b1, 2'b10, 32'h103, 64'h0000BEEF, 1'b1);
    step(1'b1, 1'b0, 2'b00, 32'h0, 64'h0, 1'b0);
    check_val("t5_rst_valid", 64'(mval_v[0]), 64'h0);
    idle(1'b1);
    idle(1'b1);

    // Word crossing the top of the address space.
    step(1'b0, 1'b1, 2'b00, 32'hFFFFFFFE, 64'h11223344, 1'b1);
    check_val("t6_addr0", 64'(maddr_v[0]), 64'hFFFFFFFC);
    check_val("t6_wdata0", 64'(wd0), 64'h33440000);
    check_val("t6_strb0", 64'(sb0), 64'hC);
    idle(1'b1);
    check_val("t6_addr1", 64'(maddr_v[0]), 64'h0);
    check_val("t6_wdata1", 64'(wd0), 64'h00001122);
    check_val("t6_strb1", 64'(sb0), 64'h3);
    idle(1'b1);
    idle(1'b1);

    // Doubleword: legal only on the 64-bit bus.
    step(1'b0, 1'b1, 2'b11, 32'h8, 64'h0123456789ABCDEF, 1'b1);
    check_val("t6_sd_strb", 64'(sb2), 64'hFF);
    check_val("t6_sd_addr", 64'(maddr_v[2]), 64'h8);
    check_val("t6_sd_wdata", wd2, 64'h0123456789ABCDEF);
    check_val("t4_sd_fault", 64'(mflt_v[0]), 64'h1);
    idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      ra = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else if (sel == 1) ra = 32'h100 + 32'($urandom_range(0, 15));
      else               ra = $urandom;
      rd = {$urandom, $urandom};
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
           ra, rd, $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
